// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator: word-granular req/ack memory port, RMW for SB/SH, extended loads
module lsu_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_wr,
  input  logic [3:0]        cpu_ctrl,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  // Bit 3 of the access code marks a store.
  localparam logic [3:0] MEM_LB  = 4'h0;
  localparam logic [3:0] MEM_LH  = 4'h1;
  localparam logic [3:0] MEM_LW  = 4'h2;
  localparam logic [3:0] MEM_LBU = 4'h4;
  localparam logic [3:0] MEM_LHU = 4'h5;
  localparam logic [3:0] MEM_SB  = 4'h8;
  localparam logic [3:0] MEM_SH  = 4'h9;
  localparam logic [3:0] MEM_SW  = 4'hA;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        legal, misaligned, timeout_hit;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;
  logic        unused_addr;

  assign unused_addr = ^cpu_addr[31:ADDR_W+2];

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (cpu_ctrl)
      MEM_LB, MEM_LBU, MEM_SB: legal = 1'b1;
      MEM_LH, MEM_LHU, MEM_SH: begin
        legal      = 1'b1;
        misaligned = cpu_addr[0];
      end
      MEM_LW, MEM_SW: begin
        legal      = 1'b1;
        misaligned = |cpu_addr[1:0];
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (ctrl_q)
      MEM_LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_val = {24'd0, byte_sel};
      MEM_LH:  load_val = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_val = {16'd0, half_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (ctrl_q == MEM_SB) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctrl_d      = ctrl_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr[ADDR_W+1:0];
          wdata_d = cpu_wdata[15:0];
          ctrl_d  = cpu_ctrl;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!legal || (cpu_wr != cpu_ctrl[3]) || misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (cpu_ctrl == MEM_SW) begin
            mem_wdata_d = cpu_wdata;
            state_d     = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          if (ctrl_q[3]) begin
            mem_wdata_d = merged;
            cnt_d       = '0;
            state_d     = S_WR;
          end else begin
            rdata_d = load_val;
            state_d = S_DONE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctrl_q      <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_busy  = (state_q != S_IDLE);
  assign cpu_done  = (state_q == S_DONE);
  assign cpu_err   = cpu_done & err_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a behavioural memory and access model
module tb_lsu_ctrl;
  localparam int AW    = 10;
  localparam int TO    = 8;
  localparam int NEVER = 1000;
  localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
  localparam logic [3:0] SB = 4'h8, SH = 4'h9, SW = 4'hA;

  logic          clk, rst_n, cpu_req, cpu_wr, cpu_busy, cpu_done, cpu_err;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [3:0]    cpu_ctrl;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;

  lsu_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_ctrl(cpu_ctrl),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic err; logic [31:0] rdata; int lat; int reqc;} exp_t;
  typedef struct {logic we; logic [31:0] waddr; logic [31:0] wdata;} op_t;

  exp_t        exp_q[$];
  op_t         op_q[$];
  logic [31:0] mem[1024];
  logic [31:0] ref_mem[1024];
  logic [31:0] model_rdata;
  logic [3:0]  codes[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
  int errors = 0, checks = 0, cyc = 0, issue_cyc = 0, req_cyc = 0;
  int ack_delay = 0, wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input int wa, input logic [31:0] v);
    mem[wa]     = v;
    ref_mem[wa] = v;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1 mem_ack = 1'b0;
  end

  // Memory responder: acks after ack_delay wait cycles and checks each transaction in order.
  initial forever begin
    op_t o;
    @(negedge clk);
    if (rst_n && mem_req) begin
      req_cyc++;
      if (wait_cnt >= ack_delay) begin
        wait_cnt = 0;
        mem_ack  = 1'b1;
        mem_rdata = mem[mem_addr];
        if (op_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_txn: got addr=%0d we=%0d, expected no transaction", mem_addr, mem_we);
        end else begin
          o = op_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(o.we));
          chk("mem_addr", 32'(mem_addr), o.waddr);
          if (o.we) begin
            chk("mem_wdata", mem_wdata, o.wdata);
            mem[mem_addr] = mem_wdata;
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (cpu_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending request");
      end else begin
        e = exp_q.pop_front();
        chk("cpu_err", 32'(cpu_err), 32'(e.err));
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("latency", 32'(cyc - issue_cyc), 32'(e.lat));
        chk("mem_req_cycles", 32'(req_cyc), 32'(e.reqc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (cpu_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cpu_busy) chk("idle_wait", 32'(cpu_busy), 32'd0);
  endtask

  task automatic issue(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wd,
                       input logic wr, input int dly);
    wait_idle();
    ack_delay = dly;
    req_cyc   = 0;
    issue_cyc = cyc;
    cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wd; cpu_wr = wr; cpu_ctrl = code;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
    cpu_ctrl = 4'($urandom); cpu_wr = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("ops_left", 32'(op_q.size()), 32'd0);
    op_q.delete();
  endtask

  // Reference model: sub-word access expressed as shifts and masks on the whole word.
  task automatic do_req(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wd,
                        input logic wr, input int dly);
    int wa, lane, sz;
    bit legal, st, sgn;
    logic [31:0] word, v, msk, nw;
    exp_t e;
    wa = int'((addr / 4) % 1024);
    lane = int'(addr % 4);
    legal = 1; st = 0; sgn = 0; sz = 1;
    case (code)
      LB:  begin sz = 1; sgn = 1; end
      LBU: sz = 1;
      LH:  begin sz = 2; sgn = 1; end
      LHU: sz = 2;
      LW:  sz = 4;
      SB:  begin sz = 1; st = 1; end
      SH:  begin sz = 2; st = 1; end
      SW:  begin sz = 4; st = 1; end
      default: legal = 0;
    endcase
    if (!legal || (wr != st) || (lane % sz != 0)) begin
      e = '{1'b1, model_rdata, 1, 0};
    end else if (dly == NEVER) begin
      e = '{1'b1, model_rdata, TO + 1, TO};
    end else begin
      word = ref_mem[wa];
      msk  = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
      if (!st) begin
        v = (word >> (8 * lane)) & msk;
        if (sgn && sz < 4 && v >= (msk + 32'h1) / 2) v = v - (msk + 32'h1);
        op_q.push_back('{1'b0, 32'(wa), 32'h0});
        model_rdata = v;
        e = '{1'b0, v, 2 + dly, dly + 1};
      end else if (sz == 4) begin
        op_q.push_back('{1'b1, 32'(wa), wd});
        ref_mem[wa] = wd;
        e = '{1'b0, model_rdata, 2 + dly, dly + 1};
      end else begin
        nw = (word & ~(msk << (8 * lane))) | ((wd & msk) << (8 * lane));
        op_q.push_back('{1'b0, 32'(wa), 32'h0});
        op_q.push_back('{1'b1, 32'(wa), nw});
        ref_mem[wa] = nw;
        e = '{1'b0, model_rdata, 3 + 2 * dly, 2 * dly + 2};
      end
    end
    exp_q.push_back(e);
    issue(code, addr, wd, wr, dly);
    wait_done();
  endtask

  initial begin
    logic [3:0]  c;
    logic        w;
    logic [31:0] a;
    int          d;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0;
    cpu_ctrl = '0; mem_ack = 1'b0; mem_rdata = '0; model_rdata = '0;
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    set_word(1, 32'h80FF_1234);
    do_req(LB, 32'h7, 32'h0, 1'b0, 0);
    chk("lb_value", cpu_rdata, 32'hFFFF_FF80);
    do_req(LBU, 32'h7, 32'h0, 1'b0, 0);
    chk("lbu_value", cpu_rdata, 32'h0000_0080);

    set_word(4, 32'h1122_3344);
    do_req(SH, 32'h12, 32'hAAAA_BEEF, 1'b1, 0);
    chk("sh_word", mem[4], 32'hBEEF_3344);
    for (int l = 0; l < 4; l++) begin
      set_word(8, 32'h0);
      do_req(SB, 32'(32 + l), 32'hFFFF_FF5A, 1'b1, 0);
      chk("sb_lane_word", mem[8], 32'h5A << (8 * l));
    end

    do_req(LW, 32'h2, 32'h0, 1'b0, 0);
    do_req(SH, 32'h13, 32'h1234_5678, 1'b1, 0);
    do_req(LW, 32'h0, 32'h0, 1'b1, 0);

    set_word(5, 32'h8000_7FFF);
    do_req(LH, 32'h16, 32'h0, 1'b0, 5);
    chk("lh_wait_value", cpu_rdata, 32'hFFFF_8000);
    do_req(LW, 32'h20, 32'h0, 1'b0, NEVER);
    chk("timeout_rdata_held", cpu_rdata, 32'hFFFF_8000);
    do_req(SB, 32'h41, 32'h77, 1'b1, NEVER);
    chk("timeout_no_write", mem[16], ref_mem[16]);

    // Reset while a SB read is outstanding.
    wait_idle();
    ack_delay = NEVER;
    cpu_req = 1'b1; cpu_ctrl = SB; cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h99;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_mem_req", 32'(mem_req), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_busy", 32'(cpu_busy), 32'd0);
    chk("async_rst_rdata", cpu_rdata, 32'd0);
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_write", mem[16], ref_mem[16]);
    do_req(LW, 32'h4, 32'h0, 1'b0, 0);
    chk("lw_after_rst", cpu_rdata, 32'h80FF_1234);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) < 8) c = codes[$urandom_range(0, 7)];
      else c = 4'($urandom);
      w = (c == SB) || (c == SH) || (c == SW);
      if ($urandom_range(0, 9) == 0) w = ~w;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a & ~32'h3;
      d = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 3));
      do_req(c, a, $urandom, w, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
